// File: rtl/arbitro_pkg.sv
// Shared definitions for the register arbiter family.
//   WORD_W  : width of the shared hold register word
//   GRANT_W : width of a requester index (supports up to 8 requesters)
//   estado_t: controller states for one register transfer
package arbitro_pkg;

  localparam int WORD_W  = 4;
  localparam int GRANT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FIM   = 2'd2,
    ST_CLEAR = 2'd3
  } estado_t;

endpackage

// File: rtl/rr_prioridade.sv
// Combinational round-robin picker.
// Returns the first asserted request at or after the pointer, wrapping
// from N-1 back to 0.
//   req_i   : request vector
//   ptr_i   : highest-priority index for this decision (must be < N)
//   valid_o : at least one request asserted
//   idx_o   : chosen index (0 when valid_o is low)
module rr_prioridade
  import arbitro_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic               valid_o,
  output logic [GRANT_W-1:0] idx_o
);

  logic [2*N-1:0]   req_dup;
  logic [N-1:0]     req_rot;
  logic [GRANT_W:0] soma;

  // Duplicating the vector and shifting by the pointer rotates it so that
  // bit k of req_rot is requester (ptr + k) mod N.
  assign req_dup = {req_i, req_i};
  assign req_rot = N'(req_dup >> ptr_i);

  // Scan from the farthest offset down so the nearest request is the last
  // one written and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    soma    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        valid_o = 1'b1;
        soma    = {1'b0, ptr_i} + (GRANT_W + 1)'(k);
        if (soma >= (GRANT_W + 1)'(N)) begin
          soma = soma - (GRANT_W + 1)'(N);
        end
        idx_o = soma[GRANT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/arbitro_registro.sv
// Round-robin arbiter sharing one external 4-bit hold register among N
// requesters. One transfer: grant, drive Hab/In until the register reports
// Fim (or a timeout expires), pulse ack with the read-back word, then wait
// for Fim to fall before the next grant.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester request, held until its ack
//   dado_req   : word of requester i at [4i+3:4i]
//   ack        : one-cycle completion pulse to the granted requester
//   dado_out   : word read back from the register, valid with ack
//   valido     : with ack, transfer completed normally
//   erro       : with ack, transfer timed out
//   ocupado    : controller not idle
//   grant_id   : current/last granted requester
//   reg_in     : register In
//   reg_hab    : register Hab
//   reg_saida  : register Saida
//   reg_fim    : register Fim ("stored and stable")
module arbitro_registro
  import arbitro_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [WORD_W*N-1:0] dado_req,
  output logic [N-1:0]        ack,
  output logic [WORD_W-1:0]   dado_out,
  output logic                valido,
  output logic                erro,
  output logic                ocupado,
  output logic [GRANT_W-1:0]  grant_id,
  output logic [WORD_W-1:0]   reg_in,
  output logic                reg_hab,
  input  logic [WORD_W-1:0]   reg_saida,
  input  logic                reg_fim
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

  estado_t             state_q, state_d;
  logic [GRANT_W-1:0]  ptr_q, ptr_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [WORD_W-1:0]   reg_in_q, reg_in_d;
  logic [WORD_W-1:0]   dado_out_q, dado_out_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                pick_valid;
  logic [GRANT_W-1:0]  pick_idx;
  logic [WORD_W-1:0]   palavra_sel;

  rr_prioridade #(
    .N (N)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Word of the requester the picker would grant this cycle.
  always_comb begin
    palavra_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == GRANT_W'(i)) begin
        palavra_sel = dado_req[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      reg_in_q   <= '0;
      dado_out_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      reg_in_q   <= reg_in_d;
      dado_out_q <= dado_out_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    reg_in_d   = reg_in_q;
    dado_out_d = dado_out_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        // req is only looked at here; once granted, the transfer runs to
        // completion regardless of what the request lines do.
        if (pick_valid) begin
          grant_d  = pick_idx;
          reg_in_d = palavra_sel;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // A Fim seen on the last allowed cycle still counts as success.
        if (reg_fim) begin
          dado_out_d = reg_saida;
          state_d    = ST_FIM;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FIM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FIM: begin
        // The requester just served gets lowest priority next time.
        if (grant_q == GRANT_W'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_q + 1'b1;
        end
        state_d = ST_CLEAR;
      end

      ST_CLEAR: begin
        // Fim left high from this transfer would otherwise finish the next
        // LOAD before the register has taken the new word.
        if (!reg_fim) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign reg_hab  = (state_q == ST_LOAD);
  assign reg_in   = reg_in_q;
  assign grant_id = grant_q;
  assign dado_out = dado_out_q;
  assign ocupado  = (state_q != ST_IDLE);
  assign ack      = (state_q == ST_FIM) ? (N'(1) << grant_q) : '0;
  assign valido   = (state_q == ST_FIM) && !err_q;
  assign erro     = (state_q == ST_FIM) && err_q;

endmodule

// File: tb/tb_arbitro_registro.sv
module tb_arbitro_registro;

  localparam int N       = 4;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [4*N-1:0] dado_req;
  logic [N-1:0]  ack;
  logic [3:0]    dado_out;
  logic          valido;
  logic          erro;
  logic          ocupado;
  logic [2:0]    grant_id;
  logic [3:0]    reg_in;
  logic          reg_hab;
  logic [3:0]    reg_saida;
  logic          reg_fim;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arbitro_registro #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dado_req  (dado_req),
    .ack       (ack),
    .dado_out  (dado_out),
    .valido    (valido),
    .erro      (erro),
    .ocupado   (ocupado),
    .grant_id  (grant_id),
    .reg_in    (reg_in),
    .reg_hab   (reg_hab),
    .reg_saida (reg_saida),
    .reg_fim   (reg_fim)
  );

  // Shared hold register: stores In while Hab is high; Fim rises once
  // Saida already equals In under Hab. Optional stuck-low Fim and extra
  // Fim hold cycles after Hab drops.
  logic [3:0] saida_q = 4'h0;
  logic       fim_q   = 1'b0;
  int         hold_q  = 0;
  bit         stuck   = 1'b0;
  int         extra   = 0;

  assign reg_saida = saida_q;
  assign reg_fim   = fim_q;

  always @(posedge clk) begin
    if (reg_hab) saida_q <= reg_in;
    if (stuck) begin
      fim_q  <= 1'b0;
      hold_q <= 0;
    end else if (reg_hab) begin
      fim_q  <= (saida_q == reg_in);
      hold_q <= (saida_q == reg_in) ? extra : 0;
    end else if (hold_q > 0) begin
      fim_q  <= 1'b1;
      hold_q <= hold_q - 1;
    end else begin
      fim_q <= 1'b0;
    end
  end

  // Completion outputs must always come as one ack bit with exactly one flag.
  always @(negedge clk) begin
    if (!rst && (ack != 0 || valido || erro)) begin
      checks++;
      if (!($countones(ack) == 1 && ocupado && (valido ^ erro))) begin
        errors++;
        $display("FAIL mon_fim: ack=%b valido=%b erro=%b ocupado=%b, required one-hot ack with exactly one flag",
                 ack, valido, erro, ocupado);
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nome, act, exp);
    end
  endtask

  task automatic wait_ack(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (!ok) begin
        @(posedge clk);
        @(negedge clk);
        lat++;
        if (ack != 0) ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ack_wait: no ack within 40 cycles, expected one");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!ok) begin
        @(posedge clk);
        @(negedge clk);
        if (!ocupado) ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_wait: still busy after 20 cycles, expected idle");
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    logic [15:0] words;
    logic [3:0]  exp_ack;
    logic [2:0]  exp_gid;
    logic [3:0]  exp_dado;
    int          exp_lat;
  } vec_t;

  vec_t tab[8];

  initial begin
    int lat;
    int ptr;
    int exp;
    int t;
    logic [N-1:0] pend;
    logic [N-1:0] novos;

    // Single transfers from idle; pointer and register contents carry over.
    // Latency: 4 cycles for a fresh word, 3 when the register already holds it.
    tab[0] = '{4'b0011, 16'h00BA, 4'b0001, 3'd0, 4'hA, 4};
    tab[1] = '{4'b0001, 16'h000A, 4'b0001, 3'd0, 4'hA, 3};
    tab[2] = '{4'b1001, 16'h7003, 4'b1000, 3'd3, 4'h7, 4};
    tab[3] = '{4'b0110, 16'h0270, 4'b0010, 3'd1, 4'h7, 3};
    tab[4] = '{4'b0011, 16'h0065, 4'b0001, 3'd0, 4'h5, 4};
    tab[5] = '{4'b0100, 16'h0500, 4'b0100, 3'd2, 4'h5, 3};
    tab[6] = '{4'b1111, 16'h9999, 4'b1000, 3'd3, 4'h9, 4};
    tab[7] = '{4'b0110, 16'h0390, 4'b0010, 3'd1, 4'h9, 3};

    rst      = 1'b1;
    req      = '0;
    dado_req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_valido", valido, 0);
    chk("rst_erro", erro, 0);
    chk("rst_dado_out", dado_out, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_reg_in", reg_in, 0);
    chk("rst_reg_hab", reg_hab, 0);
    chk("rst_ocupado", ocupado, 0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesting at once: served 0,1,2,3 in order.
    req      = 4'b1111;
    dado_req = 16'h4321;
    for (int i = 0; i < N; i++) begin
      wait_ack(lat);
      if (i == 0) chk("all_first_lat", lat, 4);
      chk("all_ack", ack, 1 << i);
      chk("all_dado", dado_out, i + 1);
      chk("all_gid", grant_id, i);
      chk("all_valido", valido, 1);
      req[i] = 1'b0;
    end
    wait_idle();

    for (int v = 0; v < 8; v++) begin
      req      = tab[v].req;
      dado_req = tab[v].words;
      wait_ack(lat);
      chk($sformatf("vec%0d_ack", v), ack, tab[v].exp_ack);
      chk($sformatf("vec%0d_gid", v), grant_id, tab[v].exp_gid);
      chk($sformatf("vec%0d_dado", v), dado_out, tab[v].exp_dado);
      chk($sformatf("vec%0d_valido", v), valido, 1);
      chk($sformatf("vec%0d_lat", v), lat, tab[v].exp_lat);
      req = '0;
      wait_idle();
    end

    // Fim never rises: error ack TIMEOUT cycles after LOAD entry.
    stuck    = 1'b1;
    req      = 4'b0010;
    dado_req = 16'h00E0;
    wait_ack(lat);
    chk("to_lat", lat, TIMEOUT + 1);
    chk("to_ack", ack, 4'b0010);
    chk("to_erro", erro, 1);
    chk("to_valido", valido, 0);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    chk("to_clear_busy", ocupado, 1);
    @(posedge clk);
    @(negedge clk);
    chk("to_back_idle", ocupado, 0);
    stuck = 1'b0;

    // Fim held 3 extra cycles: controller waits in CLEAR, next LOAD only after.
    extra    = 3;
    req      = 4'b0001;
    dado_req = 16'h0003;
    wait_ack(lat);
    chk("hold_ack", ack, 4'b0001);
    chk("hold_dado", dado_out, 4'h3);
    extra    = 0;
    req      = 4'b0100;
    dado_req = 16'h0300;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_clear_busy", ocupado, 1);
      chk("hold_clear_hab", reg_hab, 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_hab", reg_hab, 0);
    chk("hold_idle", ocupado, 0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_next_load", reg_hab, 1);
    wait_ack(lat);
    chk("hold_next_ack", ack, 4'b0100);
    chk("hold_next_dado", dado_out, 4'h3);
    req = '0;
    wait_idle();

    // Reset in the middle of LOAD, then a pending request served normally.
    req      = 4'b0001;
    dado_req = 16'h0006;
    @(posedge clk);
    @(negedge clk);
    chk("rl_in_load", reg_hab, 1);
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    req      = 4'b0100;
    dado_req = 16'h0800;
    @(posedge clk);
    @(negedge clk);
    chk("rl_hab", reg_hab, 0);
    chk("rl_ack", ack, 0);
    chk("rl_gid", grant_id, 0);
    chk("rl_ocupado", ocupado, 0);
    chk("rl_dado_out", dado_out, 0);
    rst = 1'b0;
    wait_ack(lat);
    chk("rl_after_lat", lat, 4);
    chk("rl_after_ack", ack, 4'b0100);
    chk("rl_after_gid", grant_id, 2);
    chk("rl_after_dado", dado_out, 4'h8);
    req = '0;
    wait_idle();

    // Random traffic against a pending-set round-robin model.
    pulse_reset();
    ptr      = 0;
    pend     = N'($urandom_range(1, (1 << N) - 1));
    dado_req = 16'($urandom);
    req      = pend;
    t        = 0;
    while (pend != 0 && t < 80) begin
      wait_ack(lat);
      exp = pick(pend, ptr);
      chk("rnd_ack", ack, 1 << exp);
      chk("rnd_dado", dado_out, dado_req[exp*4 +: 4]);
      chk("rnd_valido", valido, 1);
      ptr       = (exp + 1) % N;
      pend[exp] = 1'b0;
      novos     = '0;
      if (t < 40) begin
        novos = N'($urandom) & ~pend;
        if ((pend | novos) == 0) novos[$urandom_range(0, N - 1)] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (novos[i]) dado_req[i*4 +: 4] = 4'($urandom);
      end
      pend = pend | novos;
      req  = pend;
      t++;
    end
    req = '0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
